// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, station tags, the empty-value marker
// and the reservation-station FSM state type.
package tomasulo_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;

  localparam logic [2:0] FREE_REGISTER    = 3'd0;
  localparam logic [2:0] RES_STATION_ADD1 = 3'd1;
  localparam logic [2:0] RES_STATION_ADD2 = 3'd2;

  localparam logic [15:0] SEM_VALOR = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EXEC     = 2'd2,
    WB       = 2'd3
  } rs_state_e;

  // Tag 0 means "value present", so a broadcast with tag 0 never matches.
  function automatic logic cdb_hit(input logic       valid,
                                   input logic [2:0] cdb_tag,
                                   input logic [2:0] q);
    return valid && (cdb_tag != FREE_REGISTER) && (cdb_tag == q);
  endfunction

endpackage

// File: rtl/estacao_reserva_add_if.sv
// Dispatch, CDB snoop and CDB broadcast signals of one ADD/SUB reservation station.
interface estacao_reserva_add_if;
  logic        Enable_VQ;
  logic [2:0]  Ufop;
  logic [15:0] Vj;
  logic [15:0] Vk;
  logic [2:0]  Qj;
  logic [2:0]  Qk;
  logic [3:0]  R_target;
  logic        CDB_valid;
  logic [2:0]  CDB_tag;
  logic [15:0] CDB_data;
  logic        CDB_grant;
  logic        Busy;
  logic        CDB_req;
  logic [15:0] Res_data;
  logic [2:0]  Res_tag;
  logic [3:0]  Res_target;

  modport master (
    output Enable_VQ, Ufop, Vj, Vk, Qj, Qk, R_target,
    output CDB_valid, CDB_tag, CDB_data, CDB_grant,
    input  Busy, CDB_req, Res_data, Res_tag, Res_target
  );

  modport slave (
    input  Enable_VQ, Ufop, Vj, Vk, Qj, Qk, R_target,
    input  CDB_valid, CDB_tag, CDB_data, CDB_grant,
    output Busy, CDB_req, Res_data, Res_tag, Res_target
  );
endinterface

// File: rtl/ula_add_sub.sv
// Combinational ADD/SUB unit; wraps modulo 2^16, unknown opcodes yield SEM_VALOR.
module ula_add_sub
  import tomasulo_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  always_comb begin
    y = SEM_VALOR;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = SEM_VALOR;
    endcase
  end

endmodule

// File: rtl/estacao_reserva_add.sv
// ADD/SUB reservation station: captures an instruction, snoops the CDB for
// missing operands, executes for LATENCY cycles and broadcasts on grant.
module estacao_reserva_add
  import tomasulo_pkg::*;
#(
  parameter logic [2:0] TAG     = 3'd1,
  parameter int         LATENCY = 2
) (
  input logic                  Clock,
  input logic                  Reset,
  estacao_reserva_add_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  rs_state_e   state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] vj_q, vj_d, vk_q, vk_d;
  logic [2:0]  qj_q, qj_d, qk_q, qk_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cnt_load_q, cnt_load_d;
  logic [15:0] res_data_q, res_data_d;
  logic [2:0]  res_tag_q, res_tag_d;
  logic [3:0]  res_target_q, res_target_d;
  logic [15:0] alu_y;

  ula_add_sub u_ula (
    .op (op_q),
    .a  (vj_q),
    .b  (vk_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    cnt_load_d   = cnt_load_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_target_d = res_target_q;

    case (state_q)
      IDLE: begin
        if (bus.Enable_VQ) begin
          op_d     = bus.Ufop;
          target_d = bus.R_target;
          vj_d     = bus.Vj;
          qj_d     = bus.Qj;
          vk_d     = bus.Vk;
          qk_d     = bus.Qk;
          // An operand broadcast on the dispatch edge is captured directly.
          if (cdb_hit(bus.CDB_valid, bus.CDB_tag, bus.Qj)) begin
            vj_d = bus.CDB_data;
            qj_d = FREE_REGISTER;
          end
          if (cdb_hit(bus.CDB_valid, bus.CDB_tag, bus.Qk)) begin
            vk_d = bus.CDB_data;
            qk_d = FREE_REGISTER;
          end
          cnt_load_d = 1'b1;
          state_d    = (qj_d == FREE_REGISTER && qk_d == FREE_REGISTER) ? EXEC : WAIT_OPS;
        end
      end

      WAIT_OPS: begin
        if (cdb_hit(bus.CDB_valid, bus.CDB_tag, qj_q)) begin
          vj_d = bus.CDB_data;
          qj_d = FREE_REGISTER;
        end
        if (cdb_hit(bus.CDB_valid, bus.CDB_tag, qk_q)) begin
          vk_d = bus.CDB_data;
          qk_d = FREE_REGISTER;
        end
        if (qj_d == FREE_REGISTER && qk_d == FREE_REGISTER) begin
          cnt_load_d = 1'b1;
          state_d    = EXEC;
        end
      end

      EXEC: begin
        // The first EXEC cycle loads the counter; the result is taken when it reads 0.
        if (cnt_load_q) begin
          cnt_d      = CNT_INIT;
          cnt_load_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          res_data_d   = alu_y;
          res_tag_d    = TAG;
          res_target_d = target_q;
          state_d      = WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WB: begin
        if (bus.CDB_grant) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      vj_q         <= SEM_VALOR;
      vk_q         <= SEM_VALOR;
      qj_q         <= FREE_REGISTER;
      qk_q         <= FREE_REGISTER;
      target_q     <= 4'd0;
      cnt_q        <= 4'd0;
      cnt_load_q   <= 1'b0;
      res_data_q   <= SEM_VALOR;
      res_tag_q    <= FREE_REGISTER;
      res_target_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      cnt_load_q   <= cnt_load_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_target_q <= res_target_d;
    end
  end

  assign bus.Busy       = (state_q != IDLE);
  assign bus.CDB_req    = (state_q == WB);
  assign bus.Res_data   = res_data_q;
  assign bus.Res_tag    = res_tag_q;
  assign bus.Res_target = res_target_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Directed bench for the ADD/SUB reservation station (TAG=1, LATENCY=2).
module tb_estacao_reserva_add;
  import tomasulo_pkg::*;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   busy_cnt;
  int   req_cnt;
  logic [15:0] cap_data;
  logic [2:0]  cap_tag;
  logic [3:0]  cap_target;

  estacao_reserva_add_if bus();

  estacao_reserva_add #(.TAG(3'd1), .LATENCY(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                          input logic [2:0] qj, input logic [2:0] qk, input logic [3:0] tgt);
    bus.Enable_VQ = 1'b1;
    bus.Ufop      = op;
    bus.Vj        = vj;
    bus.Vk        = vk;
    bus.Qj        = qj;
    bus.Qk        = qk;
    bus.R_target  = tgt;
  endtask

  // Steps until CDB_req rises; n is the number of edges waited (20 = timed out).
  task automatic wait_req(output int cnt);
    cnt = 0;
    while (bus.CDB_req !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    Reset         = 1'b1;
    bus.Enable_VQ = 1'b0;
    bus.Ufop      = OP_NOP;
    bus.Vj        = 16'h0;
    bus.Vk        = 16'h0;
    bus.Qj        = 3'd0;
    bus.Qk        = 3'd0;
    bus.R_target  = 4'd0;
    bus.CDB_valid = 1'b0;
    bus.CDB_tag   = 3'd0;
    bus.CDB_data  = 16'h0;
    bus.CDB_grant = 1'b0;
    step();
    step();
    chk("rst busy",    32'(bus.Busy),       0);
    chk("rst req",     32'(bus.CDB_req),    0);
    chk("rst data",    32'(bus.Res_data),   'hFFF0);
    chk("rst tag",     32'(bus.Res_tag),    0);
    chk("rst target",  32'(bus.Res_target), 0);
    Reset = 1'b0;

    // Ready operands, grant held high: Busy 4 cycles, CDB_req 1 cycle.
    bus.CDB_grant = 1'b1;
    dispatch(OP_ADD, 16'd5, 16'd7, 3'd0, 3'd0, 4'd3);
    step();
    bus.Enable_VQ = 1'b0;
    busy_cnt = 0;
    req_cnt  = 0;
    cap_data = 16'h0; cap_tag = 3'd0; cap_target = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.CDB_req === 1'b1) begin
        req_cnt++;
        cap_data   = bus.Res_data;
        cap_tag    = bus.Res_tag;
        cap_target = bus.Res_target;
      end
      step();
    end
    chk("t1 busy cycles", busy_cnt, 4);
    chk("t1 req cycles",  req_cnt,  1);
    chk("t1 data",        32'(cap_data),   12);
    chk("t1 tag",         32'(cap_tag),    1);
    chk("t1 target",      32'(cap_target), 3);

    // Dependency on tag 2; tag-0 and tag-3 broadcasts must not be taken.
    dispatch(OP_SUB, 16'h1234, 16'd3, 3'd2, 3'd0, 4'd5);
    step();
    bus.Enable_VQ = 1'b0;
    chk("t2 busy wait", 32'(bus.Busy), 1);
    bus.CDB_valid = 1'b1; bus.CDB_tag = 3'd0; bus.CDB_data = 16'd99;
    step();
    bus.CDB_tag = 3'd3; bus.CDB_data = 16'd77;
    step();
    bus.CDB_valid = 1'b0;
    step();
    chk("t2 no req while waiting", 32'(bus.CDB_req), 0);
    chk("t2 still busy",           32'(bus.Busy),    1);
    bus.CDB_valid = 1'b1; bus.CDB_tag = 3'd2; bus.CDB_data = 16'd10;
    step();
    bus.CDB_valid = 1'b0;
    wait_req(n);
    chk("t2 exec latency", n, 3);
    chk("t2 data",   32'(bus.Res_data),   7);
    chk("t2 tag",    32'(bus.Res_tag),    1);
    chk("t2 target", 32'(bus.Res_target), 5);
    step();
    chk("t2 busy after grant", 32'(bus.Busy), 0);

    // Same-edge snoop resolves both equal tags; ADD wraps.
    bus.CDB_valid = 1'b1; bus.CDB_tag = 3'd2; bus.CDB_data = 16'hFFFF;
    dispatch(OP_ADD, 16'd0, 16'd0, 3'd2, 3'd2, 4'd6);
    step();
    bus.Enable_VQ = 1'b0;
    bus.CDB_valid = 1'b0;
    wait_req(n);
    chk("t3 straight to exec", n, 3);
    chk("t3 data",   32'(bus.Res_data),   'hFFFE);
    chk("t3 target", 32'(bus.Res_target), 6);
    step();
    chk("t3 busy after grant", 32'(bus.Busy), 0);

    // Grant withheld 5 cycles; Enable_VQ during stall and grant cycle ignored.
    bus.CDB_grant = 1'b0;
    dispatch(OP_SUB, 16'd1, 16'd2, 3'd0, 3'd0, 4'd9);
    step();
    bus.Enable_VQ = 1'b0;
    wait_req(n);
    chk("t4 latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      chk("t4 stall req",    32'(bus.CDB_req),    1);
      chk("t4 stall data",   32'(bus.Res_data),   'hFFFF);
      chk("t4 stall target", 32'(bus.Res_target), 9);
      chk("t4 stall busy",   32'(bus.Busy),       1);
      if (i >= 1) dispatch(OP_ADD, 16'd100, 16'd100, 3'd0, 3'd0, 4'd1);
      step();
    end
    bus.CDB_grant = 1'b1;
    step();
    chk("t4 busy on grant edge", 32'(bus.Busy),    0);
    chk("t4 req on grant edge",  32'(bus.CDB_req), 0);
    bus.Enable_VQ = 1'b0;
    step();
    chk("t4 grant-cycle enable ignored", 32'(bus.Busy), 0);

    // Reset in EXEC aborts; dispatch right after release completes.
    dispatch(OP_ADD, 16'd2, 16'd3, 3'd0, 3'd0, 4'd4);
    step();
    bus.Enable_VQ = 1'b0;
    step();
    #2 Reset = 1'b1;
    #1;
    chk("t5 rst busy",   32'(bus.Busy),       0);
    chk("t5 rst req",    32'(bus.CDB_req),    0);
    chk("t5 rst data",   32'(bus.Res_data),   'hFFF0);
    chk("t5 rst tag",    32'(bus.Res_tag),    0);
    chk("t5 rst target", 32'(bus.Res_target), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5 no req in reset", 32'(bus.CDB_req), 0);
    end
    Reset = 1'b0;
    dispatch(OP_ADD, 16'd20, 16'd22, 3'd0, 3'd0, 4'd7);
    step();
    bus.Enable_VQ = 1'b0;
    chk("t5 accept after reset", 32'(bus.Busy), 1);
    wait_req(n);
    chk("t5 latency", n, 3);
    chk("t5 data",   32'(bus.Res_data),   42);
    chk("t5 tag",    32'(bus.Res_tag),    1);
    chk("t5 target", 32'(bus.Res_target), 7);
    step();
    chk("t5 busy after grant", 32'(bus.Busy), 0);

    // Unknown opcode yields the empty-value marker.
    dispatch(3'b111, 16'd1, 16'd1, 3'd0, 3'd0, 4'd2);
    step();
    bus.Enable_VQ = 1'b0;
    wait_req(n);
    chk("t6 latency", n, 3);
    chk("t6 data",    32'(bus.Res_data), 'hFFF0);
    step();
    chk("t6 busy after grant", 32'(bus.Busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/estacao_reserva_add.md
ESTACAO_RESERVA_ADD -- requirements
Module: estacao_reserva_add

Interface
REQ-001 Parameters SHALL be: TAG, default 3'd1, own station tag (1=ADD1, 2=ADD2); LATENCY, default 2, execute cycles (legal 1..15).
REQ-002 Clock  input  1  clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Enable_VQ  input  1  dispatch strobe for this station.
REQ-005 Ufop  input  3  opcode: 3'b001 ADD, 3'b010 SUB.
REQ-006 Vj, Vk  input  16 each  operand values, meaningful only when the matching tag is 0.
REQ-007 Qj, Qk  input  3 each  producer tags; 0 means the value is present.
REQ-008 R_target  input  4  destination register, carried to the result.
REQ-009 CDB_valid  input  1, CDB_tag  input  3, CDB_data  input  16: common data bus snoop.
REQ-010 CDB_grant  input  1  bus arbiter grant; meaningful only while CDB_req=1.
REQ-011 Busy  output  1  station occupied; drives the dispatcher's Busy_ADDn.
REQ-012 CDB_req  output  1  request to broadcast.
REQ-013 Res_data  output  16, Res_tag  output  3, Res_target  output  4: broadcast payload.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT_OPS, EXEC and WB.
REQ-015 In IDLE with Enable_VQ=1, the station SHALL latch Ufop/Vj/Vk/Qj/Qk/R_target and set Busy=1 on that same edge.
REQ-016 In IDLE with Enable_VQ=1, the station SHALL go to EXEC if both post-snoop tags are 0, otherwise to WAIT_OPS.
REQ-017 Snoop: with CDB_valid=1 and CDB_tag equal to a nonzero Qj or Qk, the station SHALL load CDB_data into Vj/Vk and clear that tag.
REQ-018 Snoop SHALL apply both to incoming tags on the dispatch edge and to latched tags in WAIT_OPS.
REQ-019 A single broadcast SHALL resolve Qj and Qk together when the two tags are equal.
REQ-020 CDB_tag=0 SHALL never match.
REQ-021 WAIT_OPS -> EXEC SHALL occur on the edge where the last outstanding tag is resolved.
REQ-022 On entering EXEC, a 4-bit counter SHALL load LATENCY-1 and decrement each cycle.
REQ-023 When the counter reads 0, the station SHALL register Res_data, Res_tag=TAG and Res_target, and go to WB.
REQ-024 Arithmetic SHALL be modulo 2^16, with ADD=Vj+Vk and SUB=Vj-Vk, and no overflow flag.
REQ-025 Any other opcode SHALL produce Res_data=16'hFFF0.
REQ-026 WB SHALL hold CDB_req=1 and a stable payload until CDB_grant=1 is sampled.
REQ-027 On the grant edge, the station SHALL clear Busy and CDB_req and go to IDLE, so a dispatch is accepted on the next edge at the earliest.
REQ-028 Enable_VQ while Busy=1 SHALL be ignored with no state change; this includes the grant cycle.
REQ-029 CDB_grant outside WB SHALL be ignored.
REQ-030 Snoops outside WAIT_OPS and the dispatch edge SHALL be ignored.
REQ-031 Minimum latency, with operands ready at dispatch and grant in the first WB cycle: Busy high for LATENCY+2 cycles.

Reset
REQ-032 Reset SHALL force: state IDLE, Busy=0, CDB_req=0, Res_data=16'hFFF0, Res_tag=0, Res_target=0, Vj=Vk=16'hFFF0, Qj=Qk=0, counter=0.
REQ-033 Reset mid-operation SHALL abort the instruction with no broadcast; after release, the station SHALL accept a dispatch on the first edge.

Structure
REQ-034 Shared package tomasulo_pkg SHALL hold:
- opcodes OP_NOP=0, OP_ADD=1, OP_SUB=2
- tags FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2
- SEM_VALOR=16'hFFF0
- the FSM state type.
REQ-035 The single sub-module SHALL be ula_add_sub: a combinational opcode-to-result unit. Sequencing SHALL remain in estacao_reserva_add.

Verification
REQ-036 Ready operands: dispatch ADD, Vj=5, Vk=7, Qj=Qk=0, grant held high -> Busy high 4 cycles; CDB_req high 1 cycle; Res_data=12, Res_tag=1.
REQ-037 Dependency: dispatch SUB, Vk=3, Qj=2; after 3 cycles CDB_valid/tag=2/data=10 -> EXEC next; Res_data=7.
REQ-038 Same-edge snoop: dispatch with Qj=Qk=2 while the CDB broadcasts tag 2, data 0xFFFF, op ADD -> straight to EXEC; Res_data=0xFFFE.
REQ-039 Grant stall: withhold grant 5 cycles -> CDB_req and payload stable for 5 cycles; Busy falls on the grant edge; Enable_VQ during the stall is ignored.
REQ-040 Reset mid-EXEC: assert Reset -> all outputs at reset values immediately; no CDB_req; a new dispatch after release completes normally.
